// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter: state encoding,
// port-select codes and the default access latency.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_IBUSY = 2'd1,
        ARB_DBUSY = 2'd2
    } arb_state_e;

    localparam logic SEL_I = 1'b0;
    localparam logic SEL_D = 1'b1;

    localparam int DEFAULT_LAT = 2;

endpackage

// File: rtl/mem_arbiter_wait_cnt.sv
// Loadable down-counter that times one memory access; done_o is high while
// the counter sits at zero, i.e. in the last access cycle.
module arb_wait_cnt
    import mem_arbiter_pkg::*;
#(
    parameter int LAT = DEFAULT_LAT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic dec_i,
    output logic done_o
);

    localparam int CNT_W = $clog2(LAT) + 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CNT_INIT;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one fixed-latency memory port between instruction fetch and
// the data stage, with a fetch anti-starvation streak limit and fetch squash.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int LAT          = DEFAULT_LAT,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_kill,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ready,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_wstrb,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_ready,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                stallF,
    output logic                stallM,
    output logic                busy
);

    localparam int STRB_W   = DATA_W / 8;
    localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    arb_state_e            state_q, state_d;
    logic [STREAK_W-1:0]   streak_q, streak_d;
    logic                  kill_q, kill_d;
    logic                  if_ready_q, if_ready_d;
    logic                  dm_ready_q, dm_ready_d;
    logic [DATA_W-1:0]     if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]     dm_rdata_q, dm_rdata_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  we_q, we_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;

    logic                  grant;
    logic                  gsel;
    logic                  i_elig;
    logic                  d_elig;
    logic                  cnt_load;
    logic                  cnt_dec;
    logic                  cnt_done;

    // A port whose ready pulse is showing is still holding its old request.
    assign i_elig = if_req & ~if_ready_q & ~if_kill;
    assign d_elig = dm_req & ~dm_ready_q;

    arb_wait_cnt #(
        .LAT (LAT)
    ) u_wait_cnt (
        .clk_i  (clk),
        .rst_ni (reset),
        .load_i (cnt_load),
        .dec_i  (cnt_dec),
        .done_o (cnt_done)
    );

    always_comb begin
        state_d    = state_q;
        streak_d   = streak_q;
        kill_d     = kill_q;
        if_ready_d = 1'b0;
        dm_ready_d = 1'b0;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        grant      = 1'b0;
        gsel       = SEL_I;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                kill_d = 1'b0;
                if (d_elig && !((streak_q == STREAK_MAX) && i_elig)) begin
                    grant = 1'b1;
                    gsel  = SEL_D;
                end else if (i_elig) begin
                    grant = 1'b1;
                    gsel  = SEL_I;
                end

                if (grant) begin
                    cnt_load = 1'b1;
                    if (gsel == SEL_D) begin
                        state_d = ARB_DBUSY;
                        addr_d  = dm_addr;
                        we_d    = dm_we;
                        wdata_d = dm_wdata;
                        wstrb_d = dm_wstrb;
                        // Only data grants that bypass a waiting fetch count.
                        if (!if_req) begin
                            streak_d = '0;
                        end else if (streak_q != STREAK_MAX) begin
                            streak_d = streak_q + STREAK_W'(1);
                        end
                    end else begin
                        state_d  = ARB_IBUSY;
                        addr_d   = if_addr;
                        we_d     = 1'b0;
                        wdata_d  = '0;
                        wstrb_d  = '0;
                        streak_d = '0;
                    end
                end
            end

            ARB_IBUSY: begin
                cnt_dec = 1'b1;
                if (if_kill) begin
                    kill_d = 1'b1;
                end
                if (cnt_done) begin
                    state_d = ARB_IDLE;
                    kill_d  = 1'b0;
                    if (!(kill_q || if_kill)) begin
                        if_ready_d = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end
            end

            ARB_DBUSY: begin
                cnt_dec = 1'b1;
                if (cnt_done) begin
                    state_d    = ARB_IDLE;
                    dm_ready_d = 1'b1;
                    if (!we_q) begin
                        dm_rdata_d = mem_rdata;
                    end
                end
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ARB_IDLE;
            streak_q   <= '0;
            kill_q     <= 1'b0;
            if_ready_q <= 1'b0;
            dm_ready_q <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
        end else begin
            state_q    <= state_d;
            streak_q   <= streak_d;
            kill_q     <= kill_d;
            if_ready_q <= if_ready_d;
            dm_ready_q <= dm_ready_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
        end
    end

    assign busy      = (state_q != ARB_IDLE);
    assign mem_en    = busy;
    assign mem_we    = busy & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wstrb = wstrb_q;
    assign if_ready  = if_ready_q;
    assign dm_ready  = dm_ready_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;

    // Stalls are combinational from the requests, so gate them with the
    // asynchronous reset to keep every output low while it is asserted.
    assign stallF = reset & if_req & ~if_ready_q;
    assign stallM = reset & dm_req & ~dm_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cycle tables for the basic flows plus
// hand-written sequences for starvation and mid-access reset.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_kill;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_wstrb;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        stallF;
    logic        stallM;
    logic        busy;

    int errs;
    int checks;

    mem_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .LAT          (2),
        .MAX_D_STREAK (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_kill   (if_kill),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_wstrb  (dm_wstrb),
        .dm_rdata  (dm_rdata),
        .dm_ready  (dm_ready),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .stallF    (stallF),
        .stallM    (stallM),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h100) return 32'h00500093;
        if (a == 32'h2000) return 32'h11112222;
        return a ^ 32'hA5A5A5A5;
    endfunction

    assign mem_rdata = mem_en ? mem_fn(mem_addr) : 32'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ictl = {if_req, if_kill, dm_req, dm_we}
    // octl = {mem_en, mem_we, if_ready, dm_ready, stallF, stallM, busy}
    typedef struct {
        logic [3:0]  ictl;
        logic [31:0] ia;
        logic [31:0] da;
        logic [31:0] dwd;
        logic [3:0]  ds;
        logic [6:0]  octl;
        logic [31:0] ma;
        logic [31:0] mwd;
        logic [3:0]  ms;
        logic [31:0] ird;
        logic [31:0] drd;
    } vec_t;

    vec_t vq[$];

    initial begin
        vec_t v;
        errs   = 0;
        checks = 0;

        // Fetch only
        vq.push_back('{4'b1000, 32'h100, 32'h0, 32'h0, 4'h0, 7'b0000100, 32'h0,   32'h0, 4'h0, 32'h0, 32'h0});
        vq.push_back('{4'b1000, 32'h100, 32'h0, 32'h0, 4'h0, 7'b1000101, 32'h100, 32'h0, 4'h0, 32'h0, 32'h0});
        vq.push_back('{4'b1000, 32'h100, 32'h0, 32'h0, 4'h0, 7'b1000101, 32'h100, 32'h0, 4'h0, 32'h0, 32'h0});
        vq.push_back('{4'b1000, 32'h100, 32'h0, 32'h0, 4'h0, 7'b0010000, 32'h0,   32'h0, 4'h0, 32'h00500093, 32'h0});
        vq.push_back('{4'b0000, 32'h0,   32'h0, 32'h0, 4'h0, 7'b0000000, 32'h0,   32'h0, 4'h0, 32'h00500093, 32'h0});
        // Simultaneous fetch and load: data first, fetch in the ready cycle
        vq.push_back('{4'b1010, 32'h104, 32'h2000, 32'h0, 4'h0, 7'b0000110, 32'h0,    32'h0, 4'h0, 32'h00500093, 32'h0});
        vq.push_back('{4'b1010, 32'h104, 32'h2000, 32'h0, 4'h0, 7'b1000111, 32'h2000, 32'h0, 4'h0, 32'h00500093, 32'h0});
        vq.push_back('{4'b1010, 32'h104, 32'h2000, 32'h0, 4'h0, 7'b1000111, 32'h2000, 32'h0, 4'h0, 32'h00500093, 32'h0});
        vq.push_back('{4'b1010, 32'h104, 32'h2000, 32'h0, 4'h0, 7'b0001100, 32'h0,    32'h0, 4'h0, 32'h00500093, 32'h11112222});
        vq.push_back('{4'b1000, 32'h104, 32'h0,    32'h0, 4'h0, 7'b1000101, 32'h104,  32'h0, 4'h0, 32'h00500093, 32'h11112222});
        vq.push_back('{4'b1000, 32'h104, 32'h0,    32'h0, 4'h0, 7'b1000101, 32'h104,  32'h0, 4'h0, 32'h00500093, 32'h11112222});
        vq.push_back('{4'b1000, 32'h104, 32'h0,    32'h0, 4'h0, 7'b0010000, 32'h0,    32'h0, 4'h0, 32'hA5A5A4A1, 32'h11112222});
        vq.push_back('{4'b0000, 32'h0,   32'h0,    32'h0, 4'h0, 7'b0000000, 32'h0,    32'h0, 4'h0, 32'hA5A5A4A1, 32'h11112222});
        // Store
        vq.push_back('{4'b0011, 32'h0, 32'h3000, 32'hDEADBEEF, 4'h3, 7'b0000010, 32'h0,    32'h0,        4'h0, 32'hA5A5A4A1, 32'h11112222});
        vq.push_back('{4'b0011, 32'h0, 32'h3000, 32'hDEADBEEF, 4'h3, 7'b1100011, 32'h3000, 32'hDEADBEEF, 4'h3, 32'hA5A5A4A1, 32'h11112222});
        vq.push_back('{4'b0011, 32'h0, 32'h3000, 32'hDEADBEEF, 4'h3, 7'b1100011, 32'h3000, 32'hDEADBEEF, 4'h3, 32'hA5A5A4A1, 32'h11112222});
        vq.push_back('{4'b0011, 32'h0, 32'h3000, 32'hDEADBEEF, 4'h3, 7'b0001000, 32'h0,    32'h0,        4'h0, 32'hA5A5A4A1, 32'h11112222});
        vq.push_back('{4'b0000, 32'h0, 32'h0,    32'h0,        4'h0, 7'b0000000, 32'h0,    32'h0,        4'h0, 32'hA5A5A4A1, 32'h11112222});
        // Kill in IDLE blocks the grant; kill during IBUSY squashes the result
        vq.push_back('{4'b1100, 32'h200, 32'h0, 32'h0, 4'h0, 7'b0000100, 32'h0,   32'h0, 4'h0, 32'hA5A5A4A1, 32'h11112222});
        vq.push_back('{4'b1000, 32'h200, 32'h0, 32'h0, 4'h0, 7'b0000100, 32'h0,   32'h0, 4'h0, 32'hA5A5A4A1, 32'h11112222});
        vq.push_back('{4'b1100, 32'h200, 32'h0, 32'h0, 4'h0, 7'b1000101, 32'h200, 32'h0, 4'h0, 32'hA5A5A4A1, 32'h11112222});
        vq.push_back('{4'b1000, 32'h300, 32'h0, 32'h0, 4'h0, 7'b1000101, 32'h200, 32'h0, 4'h0, 32'hA5A5A4A1, 32'h11112222});
        vq.push_back('{4'b1000, 32'h300, 32'h0, 32'h0, 4'h0, 7'b0000100, 32'h0,   32'h0, 4'h0, 32'hA5A5A4A1, 32'h11112222});
        vq.push_back('{4'b1000, 32'h300, 32'h0, 32'h0, 4'h0, 7'b1000101, 32'h300, 32'h0, 4'h0, 32'hA5A5A4A1, 32'h11112222});
        vq.push_back('{4'b1000, 32'h300, 32'h0, 32'h0, 4'h0, 7'b1000101, 32'h300, 32'h0, 4'h0, 32'hA5A5A4A1, 32'h11112222});
        vq.push_back('{4'b1000, 32'h300, 32'h0, 32'h0, 4'h0, 7'b0010000, 32'h0,   32'h0, 4'h0, 32'hA5A5A6A5, 32'h11112222});
        vq.push_back('{4'b0000, 32'h0,   32'h0, 32'h0, 4'h0, 7'b0000000, 32'h0,   32'h0, 4'h0, 32'hA5A5A6A5, 32'h11112222});

        reset    = 1'b0;
        if_req   = 1'b0;
        if_addr  = 32'h0;
        if_kill  = 1'b0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = 32'h0;
        dm_wdata = 32'h0;
        dm_wstrb = 4'h0;
        #1;
        chk1("rst_mem_en", mem_en, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_if_ready", if_ready, 1'b0);
        chk1("rst_dm_ready", dm_ready, 1'b0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_dm_rdata", dm_rdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        next_cycle();
        next_cycle();
        #2 reset = 1'b1;
        next_cycle();

        for (int i = 0; i < vq.size(); i++) begin
            v        = vq[i];
            if_req   = v.ictl[3];
            if_kill  = v.ictl[2];
            dm_req   = v.ictl[1];
            dm_we    = v.ictl[0];
            if_addr  = v.ia;
            dm_addr  = v.da;
            dm_wdata = v.dwd;
            dm_wstrb = v.ds;
            @(negedge clk);
            chk1($sformatf("row%0d.mem_en", i), mem_en, v.octl[6]);
            chk1($sformatf("row%0d.if_ready", i), if_ready, v.octl[4]);
            chk1($sformatf("row%0d.dm_ready", i), dm_ready, v.octl[3]);
            chk1($sformatf("row%0d.stallF", i), stallF, v.octl[2]);
            chk1($sformatf("row%0d.stallM", i), stallM, v.octl[1]);
            chk1($sformatf("row%0d.busy", i), busy, v.octl[0]);
            chk($sformatf("row%0d.if_rdata", i), if_rdata, v.ird);
            chk($sformatf("row%0d.dm_rdata", i), dm_rdata, v.drd);
            if (v.octl[6]) begin
                chk1($sformatf("row%0d.mem_we", i), mem_we, v.octl[5]);
                chk($sformatf("row%0d.mem_addr", i), mem_addr, v.ma);
                chk($sformatf("row%0d.mem_wdata", i), mem_wdata, v.mwd);
                chk($sformatf("row%0d.mem_wstrb", i), {28'h0, mem_wstrb}, {28'h0, v.ms});
            end
            next_cycle();
        end

        // Starvation: four back-to-back loads with fetch pending; the fetch
        // is masked by if_kill only in each data-ready cycle.
        for (int g = 0; g < 4; g++) begin
            dm_req  = 1'b1;
            dm_we   = 1'b0;
            dm_addr = 32'h4000 + 32'(g * 4);
            if_req  = 1'b1;
            if_addr = 32'h500;
            if_kill = 1'b0;
            @(negedge clk);
            chk1($sformatf("stv%0d.idle", g), busy, 1'b0);
            next_cycle();
            @(negedge clk);
            chk1($sformatf("stv%0d.d_en", g), mem_en, 1'b1);
            chk($sformatf("stv%0d.d_addr", g), mem_addr, 32'h4000 + 32'(g * 4));
            next_cycle();
            next_cycle();
            if_kill = 1'b1;
            @(negedge clk);
            chk1($sformatf("stv%0d.dm_ready", g), dm_ready, 1'b1);
            chk($sformatf("stv%0d.dm_rdata", g), dm_rdata, (32'h4000 + 32'(g * 4)) ^ 32'hA5A5A5A5);
            chk1($sformatf("stv%0d.stallF", g), stallF, 1'b1);
            next_cycle();
        end
        dm_addr = 32'h4010;
        if_kill = 1'b0;
        @(negedge clk);
        chk1("stv4.idle", busy, 1'b0);
        next_cycle();
        @(negedge clk);
        chk1("stv4.i_en", mem_en, 1'b1);
        chk("stv4.i_addr", mem_addr, 32'h500);
        chk1("stv4.stallM", stallM, 1'b1);
        chk("stv4.streak_clear", 32'(dut.streak_q), 32'h0);
        next_cycle();
        next_cycle();
        if_kill = 1'b1;
        @(negedge clk);
        chk1("stv4.if_ready_kill_in_ready", if_ready, 1'b1);
        chk("stv4.if_rdata", if_rdata, 32'hA5A5A0A5);
        chk1("stv4.stallF", stallF, 1'b0);
        next_cycle();
        if_req  = 1'b0;
        if_kill = 1'b0;
        @(negedge clk);
        chk1("stv5.d_en", mem_en, 1'b1);
        chk("stv5.d_addr", mem_addr, 32'h4010);
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk1("stv5.dm_ready", dm_ready, 1'b1);
        chk("stv5.dm_rdata", dm_rdata, 32'hA5A5E5B5);
        next_cycle();
        dm_req = 1'b0;
        next_cycle();

        // Reset in the first DBUSY cycle abandons the access
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h6000;
        if_req  = 1'b1;
        if_addr = 32'h700;
        @(negedge clk);
        chk1("rstm.idle", busy, 1'b0);
        next_cycle();
        @(negedge clk);
        chk1("rstm.en_before", mem_en, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk1("rstm.mem_en", mem_en, 1'b0);
        chk1("rstm.busy", busy, 1'b0);
        chk1("rstm.stallF", stallF, 1'b0);
        chk1("rstm.stallM", stallM, 1'b0);
        chk1("rstm.dm_ready", dm_ready, 1'b0);
        chk1("rstm.mem_we", mem_we, 1'b0);
        chk("rstm.if_rdata", if_rdata, 32'h0);
        chk("rstm.dm_rdata", dm_rdata, 32'h0);
        next_cycle();
        chk1("rstm.hold_en", mem_en, 1'b0);
        if_req = 1'b0;
        #2 reset = 1'b1;
        @(negedge clk);
        chk1("rstm.no_ready", dm_ready, 1'b0);
        chk1("rstm.stallM_after", stallM, 1'b1);
        next_cycle();
        @(negedge clk);
        chk1("rstm.regrant_en", mem_en, 1'b1);
        chk("rstm.regrant_addr", mem_addr, 32'h6000);
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk1("rstm.dm_ready_after", dm_ready, 1'b1);
        chk("rstm.dm_rdata_after", dm_rdata, 32'hA5A5C5A5);
        next_cycle();
        dm_req = 1'b0;
        @(negedge clk);
        chk1("rstm.final_idle", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
